// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared types and constants for the contador_arbitro slice
package contador_pkg;

  localparam logic [7:0] RESET_VALUE_DEF = 8'h6A;
  localparam int         AMOUNT_W        = 4;
  localparam int         IDX_W           = 3;
  localparam logic       DIR_UP          = 1'b1;
  localparam logic       DIR_DOWN        = 1'b0;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at last+1
module rr_arbiter
  import contador_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // Offsets scanned in priority order; the inner loop keeps every select constant.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && req[j] && ((int'(last) + k) % N_REQ) == j) begin
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/contador_arbitro.sv
// rtl/contador_arbitro.sv - round-robin burst controller for the shared up/down counter
// Optional saturation instead of wrap-around: CONTADOR_ARBITRO_SATURATE_EN
module contador_arbitro
  import contador_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter logic [7:0] RESET_VALUE = RESET_VALUE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_dir,
  input  logic [AMOUNT_W*N_REQ-1:0] req_amount,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      acrescer,
  output logic                      decrecer,
  output logic [7:0]                valor,
  output logic                      busy,
  output logic [IDX_W-1:0]          dono,
  output logic                      sat
);

  state_t              state_q, state_d;
  logic [AMOUNT_W-1:0] remaining_q, remaining_d;
  logic [7:0]          valor_q, valor_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    dono_q, dono_d;
  logic                dir_q, dir_d;
  logic                acrescer_q, acrescer_d;
  logic                decrecer_q, decrecer_d;
  logic                sat_q, sat_d;

  logic [N_REQ-1:0]    grant;
  logic [IDX_W-1:0]    win_idx;
  logic [AMOUNT_W-1:0] amt_sel;
  logic                dir_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant),
    .idx   (win_idx)
  );

  always_comb begin
    amt_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) amt_sel = req_amount[i*AMOUNT_W +: AMOUNT_W];
    end
  end

  assign dir_sel = |(req_dir & grant);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    valor_d     = valor_q;
    last_d      = last_q;
    dono_d      = dono_q;
    dir_d       = dir_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          last_d = win_idx;
          dono_d = win_idx;
          if (amt_sel != '0) begin
            dir_d       = dir_sel;
            remaining_d = amt_sel;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (acrescer_q)      valor_d = valor_q + 8'd1;
        else if (decrecer_q) valor_d = valor_q - 8'd1;
        remaining_d = remaining_q - AMOUNT_W'(1);
        if (sat_q || remaining_q == AMOUNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so the next cycle's step is judged on the next valor.
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    sat_d = (state_d == RUN) &&
            ((dir_d == DIR_UP   && valor_d == 8'hFF) ||
             (dir_d == DIR_DOWN && valor_d == 8'h00));
`else
    sat_d = 1'b0;
`endif
    acrescer_d = (state_d == RUN) && (dir_d == DIR_UP)   && !sat_d;
    decrecer_d = (state_d == RUN) && (dir_d == DIR_DOWN) && !sat_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      valor_q     <= RESET_VALUE;
      last_q      <= IDX_W'(N_REQ - 1);
      dono_q      <= '0;
      dir_q       <= DIR_DOWN;
      acrescer_q  <= 1'b0;
      decrecer_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      valor_q     <= valor_d;
      last_q      <= last_d;
      dono_q      <= dono_d;
      dir_q       <= dir_d;
      acrescer_q  <= acrescer_d;
      decrecer_q  <= decrecer_d;
      sat_q       <= sat_d;
    end
  end

  assign acrescer = acrescer_q;
  assign decrecer = decrecer_q;
  assign valor    = valor_q;
  assign busy     = (state_q == RUN);
  assign dono     = dono_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_contador_arbitro.sv
// tb/tb_contador_arbitro.sv - randomized and directed bench for contador_arbitro
module tb_contador_arbitro;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_dir, req_ready;
  logic [4*N-1:0] req_amount;
  logic         acrescer, decrecer, busy, sat;
  logic [7:0]   valor;
  logic [2:0]   dono;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int m_valor;
  int m_last;

  contador_arbitro dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .acrescer   (acrescer),
    .decrecer   (decrecer),
    .valor      (valor),
    .busy       (busy),
    .dono       (dono),
    .sat        (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [4*N-1:0] one_amt(input int i, input int n);
    logic [4*N-1:0] r;
    r = '0;
    r[4*i +: 4] = 4'(n);
    return r;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0; req_dir = '0; req_amount = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_valor = 8'h6A;
    m_last  = N - 1;
  endtask

  // Presents one request set in an IDLE cycle, follows the resulting burst,
  // and returns in the first IDLE cycle after it.
  task automatic round(input logic [N-1:0] v, input logic [N-1:0] d,
                       input logic [4*N-1:0] a, output int win, output int hs);
    int w, n, steps, exp_cyc, cyc, nstr, k, start, ev;
    logic up, exp_sat;
    req_valid = v; req_dir = d; req_amount = a;
    #1;
    w = rr_pick(v, m_last);
    win = w;
    check("grant", {28'd0, req_ready}, 32'(1 << w));
    n     = int'(a[4*w +: 4]);
    up    = d[w];
    start = m_valor;
    steps = n;
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    if (up) steps = (n < 255 - start) ? n : 255 - start;
    else    steps = (n < start) ? n : start;
`endif
    exp_sat = (steps < n);
    exp_cyc = exp_sat ? steps + 1 : n;
    @(posedge clk); #1;
    hs = cyc_cnt;
    m_last = w;
    cyc = 0; nstr = 0;
    while (busy === 1'b1 && cyc < 20) begin
      k  = (cyc < steps) ? cyc : steps;
      ev = (up ? start + k : start - k) & 255;
      check("ready_in_run", {28'd0, req_ready}, 0);
      check("run_valor", {24'd0, valor}, ev);
      check("run_dono", {29'd0, dono}, w);
      check("strobe_on", {31'd0, acrescer | decrecer}, (cyc < steps) ? 1 : 0);
      check("strobe_excl", {31'd0, acrescer & decrecer}, 0);
      if (acrescer | decrecer) begin
        nstr++;
        check("strobe_dir", {31'd0, acrescer}, {31'd0, up});
      end
      check("sat_pulse", {31'd0, sat}, (exp_sat && cyc == steps) ? 1 : 0);
      req_dir = N'($urandom); req_amount = (4*N)'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    m_valor = (up ? start + steps : start - steps) & 255;
    check("burst_cycles", cyc, exp_cyc);
    check("burst_strobes", nstr, steps);
    check("end_valor", {24'd0, valor}, m_valor);
    check("end_dono", {29'd0, dono}, w);
    check("end_strobes", {30'd0, acrescer, decrecer}, 0);
    check("end_sat", {31'd0, sat}, 0);
  endtask

  initial begin
    int w, hs, prev_hs;
    reset_dut();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_valor", {24'd0, valor}, 32'h6A);
      check("idle_strobes", {30'd0, acrescer, decrecer}, 0);
      check("idle_ready", {28'd0, req_ready}, 0);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_dono", {29'd0, dono}, 0);
      check("idle_sat", {31'd0, sat}, 0);
      @(posedge clk); #1;
    end

    // Requester 0 up by 3: 6A -> 6D
    round(4'b0001, 4'b0001, one_amt(0, 3), w, hs);
    check("up3_valor", {24'd0, valor}, 32'h6D);

    // All four held with amount 1: order 0,1,2,3,0, two cycles apart
    reset_dut();
    prev_hs = 0;
    for (int i = 0; i < 5; i++) begin
      round(4'b1111, 4'b1111, 16'h1111, w, hs);
      check("rr_order", w, i % N);
      if (i > 0) check("rr_spacing", hs - prev_hs, 2);
      prev_hs = hs;
    end

    // Zero-amount accept by requester 1, then an immediate follow-up grant
    round(4'b0010, 4'b0000, one_amt(1, 0), w, hs);
    check("zero_dono", {29'd0, dono}, 1);
    prev_hs = hs;
    round(4'b0100, 4'b0000, one_amt(2, 2), w, hs);
    check("zero_follow", hs - prev_hs, 1);

    // Climb to FE, then up by 3 across the top
    reset_dut();
    for (int i = 0; i < 9; i++) round(4'b0001, 4'b0001, one_amt(0, 15), w, hs);
    round(4'b0001, 4'b0001, one_amt(0, 13), w, hs);
    check("at_fe", {24'd0, valor}, 32'hFE);
    round(4'b0001, 4'b0001, one_amt(0, 3), w, hs);
`ifdef CONTADOR_ARBITRO_SATURATE_EN
    check("top_valor", {24'd0, valor}, 32'hFF);
`else
    check("top_valor", {24'd0, valor}, 32'h01);
`endif

    // Reset in the middle of a 10-step burst
    req_valid = 4'b0001; req_dir = 4'b0001; req_amount = one_amt(0, 10);
    #1;
    check("mid_grant", {28'd0, req_ready}, 1);
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_running", {30'd0, acrescer, busy}, 3);
    req_valid = '0;
    reset_dut();
    check("mid_valor", {24'd0, valor}, 32'h6A);
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_dono", {29'd0, dono}, 0);
    for (int i = 0; i < 5; i++) begin
      check("mid_no_strobe", {30'd0, acrescer, decrecer}, 0);
      @(posedge clk); #1;
    end

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      round(N'($urandom_range(1, 15)), N'($urandom), (4*N)'($urandom), w, hs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
